guitar_input_conditioner: RTL and testbench
===========================================

GUITAR_INPUT_CONDITIONER -- requirements
Module: guitar_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of clocks an input must be steady before it is accepted (10 ms at 50 MHz; legal range 2..2^20-1).
REQ-002 SHALL have port clock, input, 1, the single system clock (CLOCK_50 domain).
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls, input, 1 each, raw asynchronous guitar contacts, active-low (0 = pressed/strummed).
REQ-005 SHALL have port guitar_in, output, 6, debounced active-high fret levels {p2b3,p2b2,p2b1,p1b3,p1b2,p1b1}, feeding the VGA game logic.
REQ-006 SHALL have ports p1_hit_valid and p2_hit_valid, output, 1 each, strum event pending.
REQ-007 SHALL have ports p1_hit_frets and p2_hit_frets, output, 3 each, fret snapshot {b3,b2,b1} captured at the strum.
REQ-008 SHALL have ports p1_hit_ready and p2_hit_ready, input, 1 each, consumer accepts the pending event.
REQ-009 SHALL have ports p1_drop_count and p2_drop_count, output, 8 each, saturating count of strums lost while an event was pending.

Function
REQ-010 SHALL pass each raw input through a two-flop synchronizer and then invert it to active-high.
REQ-011 SHALL keep a per-channel stable bit and counter; the counter clears whenever the synchronized value equals stable, and otherwise increments.
REQ-012 SHALL load stable from the synchronized value and clear the counter on the cycle the counter reaches DEBOUNCE_CYCLES-1, giving raw-to-guitar_in latency of exactly 2+DEBOUNCE_CYCLES clocks.
REQ-013 SHALL discard any disturbance shorter than DEBOUNCE_CYCLES synchronized cycles, leaving stable unchanged.
REQ-014 SHALL drive guitar_in directly from the six fret stable bits, with no additional register stage.
REQ-015 SHALL generate an internal one-cycle strum pulse per player on a 0->1 transition of that player's stable ls bit; a held strum produces no further pulses.
REQ-016 On a strum pulse, when hit_valid=0 or (hit_valid=1 and hit_ready=1) in the same cycle, SHALL load hit_frets from the stable fret bits of the cycle in which the pulse is asserted and set hit_valid=1 next cycle.
REQ-017 On a strum pulse with hit_valid=1 and hit_ready=0, SHALL leave hit_frets unchanged and increment drop_count, saturating at 255.
REQ-018 SHALL clear hit_valid on the cycle after hit_ready=1 with hit_valid=1 and no strum pulse; hit_ready while hit_valid=0 has no effect.
REQ-019 SHALL hold hit_frets stable while hit_valid=1; an open strum (frets 000) is a legal event.
REQ-020 SHALL keep the two players fully independent, including simultaneous strums.

Reset
REQ-021 On reset, SHALL set synchronizer flops to 1 (released) and all stable bits, counters, hit_valid, hit_frets and drop_count to 0.
REQ-022 SHALL let reset asserted mid-operation discard any pending event and any partial debounce count, and SHALL NOT produce a strum pulse on the first cycle after reset.

Configuration
REQ-023 With GUITAR_DEBOUNCE_EN defined, SHALL implement debounce per REQ-011..013.
REQ-024 Without GUITAR_DEBOUNCE_EN, SHALL drive stable directly from the synchronizer output (latency 2 clocks), remove the counters, and ignore DEBOUNCE_CYCLES; all other behaviour is unchanged.

Structure
REQ-025 SHALL place NUM_FRETS=3, the channel index constants (P1B1..P2LS = 0..7) and the DEBOUNCE_CYCLES default in the shared package guitar_pong_pkg.
REQ-026 SHALL implement synchronizer and debounce in sub-module debounce_channel, instantiated eight times; hit-event logic stays in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset test: assert reset for 3 cycles with all raw inputs at 0 -> all outputs 0 and no hit_valid for 10 cycles after release.
REQ-028 Latency test: drive p1b2 low and hold -> guitar_in=6'b000010 exactly 6 clocks later; release -> returns to 0 6 clocks after release.
REQ-029 Glitch test: pulse p2b1 low for 3 clocks -> guitar_in[3] stays 0 throughout.
REQ-030 Hit test: hold p1b1 and p1b3, strum p1ls -> p1_hit_valid=1 with p1_hit_frets=3'b101, held until p1_hit_ready=1 for one cycle, then p1_hit_valid=0.
REQ-031 Backpressure test: strum p2 twice with p2_hit_ready=0 -> frets keep the first snapshot and p2_drop_count=1; strum again with ready=1 in the pulse cycle -> new snapshot loaded and valid stays 1; 300 blocked strums -> drop_count=255.
REQ-032 Build without GUITAR_DEBOUNCE_EN: p1b1 low for 1 clock -> guitar_in[0]=1 for exactly 1 clock, 2 clocks after the input change.

Source files
------------

// File: rtl/guitar_pong_pkg.sv
// Shared constants and helpers for the guitar pong input path.
package guitar_pong_pkg;

    localparam int NUM_FRETS               = 3;
    localparam int NUM_CHANNELS            = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_CNT_W          = 20;
    localparam int DROP_W                  = 8;

    localparam int P1B1 = 0;
    localparam int P1B2 = 1;
    localparam int P1B3 = 2;
    localparam int P1LS = 3;
    localparam int P2B1 = 4;
    localparam int P2B2 = 5;
    localparam int P2B3 = 6;
    localparam int P2LS = 7;

    typedef logic [NUM_FRETS-1:0] frets_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
        if (value == {DROP_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/guitar_input_conditioner_debounce.sv
// One raw contact: two-flop synchronizer, inversion to active-high and optional debounce.
// Debounce counter present only when GUITAR_DEBOUNCE_EN is defined.
module debounce_channel
    import guitar_pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic sync1_r;
    logic sync2_r;
    logic sync_s;

    // Two-flop synchronizer; resets to the released (high) contact level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    assign sync_s = ~sync2_r;

`ifdef GUITAR_DEBOUNCE_EN
    localparam logic [DEBOUNCE_CNT_W-1:0] LAST_COUNT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DEBOUNCE_CNT_W-1:0] count_r;
    logic                      stable_r;

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_r <= 1'b0;
            count_r  <= {DEBOUNCE_CNT_W{1'b0}};
        end else if (sync_s == stable_r) begin
            count_r  <= {DEBOUNCE_CNT_W{1'b0}};
        end else if (count_r == LAST_COUNT) begin
            stable_r <= sync_s;
            count_r  <= {DEBOUNCE_CNT_W{1'b0}};
        end else begin
            count_r  <= count_r + 20'd1;
        end
    end

    assign stable = stable_r;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = (DEBOUNCE_CYCLES == 0);
    assign stable       = sync_s;
`endif

endmodule

// File: rtl/guitar_input_conditioner.sv
// Conditions two guitar controllers into fret levels and backpressured strum events.
// Define GUITAR_DEBOUNCE_EN to enable contact debounce in every channel.
module guitar_input_conditioner
    import guitar_pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p1b1,
    input  logic       p1b2,
    input  logic       p1b3,
    input  logic       p1ls,
    input  logic       p2b1,
    input  logic       p2b2,
    input  logic       p2b3,
    input  logic       p2ls,
    output logic [5:0] guitar_in,
    output logic       p1_hit_valid,
    output logic       p2_hit_valid,
    output logic [2:0] p1_hit_frets,
    output logic [2:0] p2_hit_frets,
    input  logic       p1_hit_ready,
    input  logic       p2_hit_ready,
    output logic [7:0] p1_drop_count,
    output logic [7:0] p2_drop_count
);

    logic [NUM_CHANNELS-1:0] raw_s;
    logic [NUM_CHANNELS-1:0] stable_s;
    logic [1:0]              ls_stable_s;
    logic [1:0]              ls_prev_r;
    logic [1:0]              strum_s;
    logic [1:0]              hit_ready_s;
    logic [1:0]              hit_valid_r;
    frets_t                  fret_stable_s [2];
    frets_t                  hit_frets_r   [2];
    logic [DROP_W-1:0]       drop_r        [2];

    assign raw_s = {p2ls, p2b3, p2b2, p2b1, p1ls, p1b3, p1b2, p1b1};

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clock (clock),
            .reset (reset),
            .raw   (raw_s[ch]),
            .stable(stable_s[ch])
        );
    end

    assign guitar_in        = {stable_s[P2B3:P2B1], stable_s[P1B3:P1B1]};
    assign fret_stable_s[0] = stable_s[P1B3:P1B1];
    assign fret_stable_s[1] = stable_s[P2B3:P2B1];
    assign ls_stable_s      = {stable_s[P2LS], stable_s[P1LS]};
    assign hit_ready_s      = {p2_hit_ready, p1_hit_ready};

    // Previous ls level starts at 0 so no strum can fire on the first cycle after reset.
    assign strum_s = ls_stable_s & ~ls_prev_r;

    // Single-entry event slot per player; strums arriving while it is blocked are counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            ls_prev_r   <= 2'b00;
            hit_valid_r <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                hit_frets_r[p] <= {NUM_FRETS{1'b0}};
                drop_r[p]      <= {DROP_W{1'b0}};
            end
        end else begin
            ls_prev_r <= ls_stable_s;
            for (int p = 0; p < 2; p++) begin
                if (strum_s[p] && (!hit_valid_r[p] || hit_ready_s[p])) begin
                    hit_frets_r[p] <= fret_stable_s[p];
                    hit_valid_r[p] <= 1'b1;
                end else if (strum_s[p]) begin
                    drop_r[p]      <= sat_inc(drop_r[p]);
                end else if (hit_valid_r[p] && hit_ready_s[p]) begin
                    hit_valid_r[p] <= 1'b0;
                end else begin
                    hit_valid_r[p] <= hit_valid_r[p];
                end
            end
        end
    end

    assign p1_hit_valid  = hit_valid_r[0];
    assign p2_hit_valid  = hit_valid_r[1];
    assign p1_hit_frets  = hit_frets_r[0];
    assign p2_hit_frets  = hit_frets_r[1];
    assign p1_drop_count = drop_r[0];
    assign p2_drop_count = drop_r[1];

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Self-checking bench: a cycle model of the contact history and event slot, plus directed literal checks.
`timescale 1ns/1ps
module tb_guitar_input_conditioner;

    localparam int DEB = 4;
`ifdef GUITAR_DEBOUNCE_EN
    localparam int LAT    = 2 + DEB;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 2;
    localparam bit DEB_ON = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls;
    logic [5:0] guitar_in;
    logic       p1_hit_valid, p2_hit_valid;
    logic [2:0] p1_hit_frets, p2_hit_frets;
    logic       p1_hit_ready, p2_hit_ready;
    logic [7:0] p1_drop_count, p2_drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    guitar_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .reset(reset),
        .p1b1(p1b1), .p1b2(p1b2), .p1b3(p1b3), .p1ls(p1ls),
        .p2b1(p2b1), .p2b2(p2b2), .p2b3(p2b3), .p2ls(p2ls),
        .guitar_in(guitar_in),
        .p1_hit_valid(p1_hit_valid), .p2_hit_valid(p2_hit_valid),
        .p1_hit_frets(p1_hit_frets), .p2_hit_frets(p2_hit_frets),
        .p1_hit_ready(p1_hit_ready), .p2_hit_ready(p2_hit_ready),
        .p1_drop_count(p1_drop_count), .p2_drop_count(p2_drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw samples (active-low, newest first), accepted levels and per-player event slots.
    logic [7:0] hist [0:DEB+1];
    logic [7:0] m_stable;
    logic [1:0] m_prev;
    logic [1:0] m_valid;
    logic [2:0] m_frets [2];
    int         m_drop  [2];
    bit         model_live = 1'b0;

    task automatic step_model();
        logic [7:0] raw_now;
        logic [1:0] rdy;
        logic [1:0] pulse;
        logic [2:0] cur_frets;
        bit         same;
        raw_now = {p2ls, p2b3, p2b2, p2b1, p1ls, p1b3, p1b2, p1b1};
        rdy     = {p2_hit_ready, p1_hit_ready};
        if (reset) begin
            for (int k = 0; k <= DEB + 1; k++) hist[k] = 8'hFF;
            m_stable = 8'h00;
            m_prev   = 2'b00;
            m_valid  = 2'b00;
            for (int p = 0; p < 2; p++) begin
                m_frets[p] = 3'b000;
                m_drop[p]  = 0;
            end
            model_live = 1'b1;
            return;
        end
        pulse = {m_stable[7], m_stable[3]} & ~m_prev;
        for (int p = 0; p < 2; p++) begin
            cur_frets = (p == 0) ? m_stable[2:0] : m_stable[6:4];
            if (pulse[p]) begin
                if (!m_valid[p] || rdy[p]) begin
                    m_frets[p] = cur_frets;
                    m_valid[p] = 1'b1;
                end else if (m_drop[p] < 255) begin
                    m_drop[p] = m_drop[p] + 1;
                end
            end else if (m_valid[p] && rdy[p]) begin
                m_valid[p] = 1'b0;
            end
        end
        m_prev = {m_stable[7], m_stable[3]};
        if (DEB_ON) begin
            // A level is accepted once the last DEB synchronized samples all agree on it.
            for (int ch = 0; ch < 8; ch++) begin
                same = 1'b1;
                for (int k = 2; k <= DEB; k++) if (hist[k][ch] != hist[1][ch]) same = 1'b0;
                if (same) m_stable[ch] = ~hist[1][ch];
            end
        end else begin
            m_stable = ~hist[0];
        end
        for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw_now;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            step_model();
            #1;
            if (model_live) begin
                chk("m_guitar_in", 32'(guitar_in), 32'({m_stable[6:4], m_stable[2:0]}));
                chk("m_p1_valid", 32'(p1_hit_valid), 32'(m_valid[0]));
                chk("m_p2_valid", 32'(p2_hit_valid), 32'(m_valid[1]));
                chk("m_p1_frets", 32'(p1_hit_frets), 32'(m_frets[0]));
                chk("m_p2_frets", 32'(p2_hit_frets), 32'(m_frets[1]));
                chk("m_p1_drop", 32'(p1_drop_count), 32'(m_drop[0]));
                chk("m_p2_drop", 32'(p2_drop_count), 32'(m_drop[1]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strum2(input int hold);
        p2ls = 1'b0;
        cyc(hold);
        p2ls = 1'b1;
        cyc(hold);
    endtask

    initial begin
        {p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls} = 8'h00;
        p1_hit_ready = 1'b0;
        p2_hit_ready = 1'b0;
        reset        = 1'b1;
        cyc(3);
        reset = 1'b0;
        {p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls} = 8'hFF;
        chk("rst_p1_frets", 32'(p1_hit_frets), 32'd0);
        chk("rst_p2_drop", 32'(p2_drop_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("rst_guitar_in", 32'(guitar_in), 32'd0);
            chk("rst_valid", 32'({p2_hit_valid, p1_hit_valid}), 32'd0);
        end

        // Latency on p1b2 press and release.
        p1b2 = 1'b0;
        cyc(LAT - 1);
        chk("lat_press_early", 32'(guitar_in), 32'd0);
        cyc(1);
        chk("lat_press", 32'(guitar_in), 32'b000010);
        cyc(3);
        p1b2 = 1'b1;
        cyc(LAT - 1);
        chk("lat_release_early", 32'(guitar_in), 32'b000010);
        cyc(1);
        chk("lat_release", 32'(guitar_in), 32'd0);

`ifdef GUITAR_DEBOUNCE_EN
        p2b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("glitch_during", 32'(guitar_in[3]), 32'd0);
        end
        p2b1 = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            cyc(1);
            chk("glitch_after", 32'(guitar_in[3]), 32'd0);
        end
`else
        p1b1 = 1'b0;
        cyc(1);
        p1b1 = 1'b1;
        chk("pass_edge1", 32'(guitar_in[0]), 32'd0);
        cyc(1);
        chk("pass_edge2", 32'(guitar_in[0]), 32'd1);
        cyc(1);
        chk("pass_edge3", 32'(guitar_in[0]), 32'd0);
        cyc(1);
`endif

        // Hit with frets b1+b3 on player 1.
        p1b1 = 1'b0;
        p1b3 = 1'b0;
        cyc(LAT + 1);
        p1ls = 1'b0;
        cyc(LAT + 2);
        chk("hit_valid", 32'(p1_hit_valid), 32'd1);
        chk("hit_frets", 32'(p1_hit_frets), 32'b101);
        cyc(3);
        chk("hit_hold", 32'({p1_hit_valid, p1_hit_frets}), 32'b1101);
        p1_hit_ready = 1'b1;
        cyc(1);
        p1_hit_ready = 1'b0;
        chk("hit_consumed", 32'(p1_hit_valid), 32'd0);
        p1ls = 1'b1;
        p1b1 = 1'b1;
        p1b3 = 1'b1;
        cyc(LAT + 2);
        chk("hit_no_repeat", 32'(p1_hit_valid), 32'd0);

        // Backpressure on player 2.
        p2b2 = 1'b0;
        cyc(LAT + 1);
        strum2(LAT + 2);
        chk("bp_first", 32'({p2_hit_valid, p2_hit_frets}), 32'b1010);
        p2b2 = 1'b1;
        p2b3 = 1'b0;
        cyc(LAT + 1);
        strum2(LAT + 2);
        chk("bp_kept_frets", 32'(p2_hit_frets), 32'b010);
        chk("bp_drop1", 32'(p2_drop_count), 32'd1);
        p2ls = 1'b0;
        cyc(LAT);
        p2_hit_ready = 1'b1;
        cyc(1);
        p2_hit_ready = 1'b0;
        chk("bp_reload", 32'({p2_hit_valid, p2_hit_frets}), 32'b1100);
        chk("bp_reload_drop", 32'(p2_drop_count), 32'd1);
        p2ls = 1'b1;
        cyc(LAT + 1);
        for (int i = 0; i < 300; i++) strum2(LAT + 1);
        chk("bp_saturate", 32'(p2_drop_count), 32'd255);
        chk("bp_p1_indep", 32'(p1_drop_count), 32'd0);

        // Mid-operation reset discards the pending event, then simultaneous strums.
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("mid_rst", 32'({p2_hit_valid, p2_drop_count}), 32'd0);
        p2b3 = 1'b1;
        p1b2 = 1'b0;
        p2b1 = 1'b0;
        cyc(LAT + 1);
        p1ls = 1'b0;
        p2ls = 1'b0;
        cyc(LAT + 2);
        chk("sim_p1", 32'({p1_hit_valid, p1_hit_frets}), 32'b1010);
        chk("sim_p2", 32'({p2_hit_valid, p2_hit_frets}), 32'b1001);
        p1_hit_ready = 1'b1;
        p2_hit_ready = 1'b1;
        cyc(1);
        p1_hit_ready = 1'b0;
        p2_hit_ready = 1'b0;
        chk("sim_consumed", 32'({p2_hit_valid, p1_hit_valid}), 32'd0);
        {p1b1, p1b2, p1b3, p1ls, p2b1, p2b2, p2b3, p2ls} = 8'hFF;
        cyc(LAT + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
